// File: rtl/dest_reg_tracker.sv
// Tracks the destination register of in-flight instructions through EX/MEM/WB
// and raises load-use stall/bubble controls for hazards forwarding cannot cover.
module dest_reg_tracker #(
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             id_rd_idx,
  input  logic                   id_rd_wr_en,
  input  logic                   id_is_load,
  input  logic [4:0]             id_rs1_idx,
  input  logic [4:0]             id_rs2_idx,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic                   ex_branch_taken,
  input  logic                   mem_stall,
  output logic [4:0]             ex_reg_wr_idx,
  output logic                   ex_reg_wr_en,
  output logic [4:0]             mem_reg_wr_idx,
  output logic                   mem_reg_wr_en,
  output logic [4:0]             wb_reg_wr_idx,
  output logic                   wb_reg_wr_en,
  output logic                   load_use_stall,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   idex_bubble,
  output logic [STALL_CNT_W-1:0] load_use_stall_count
);

  typedef struct packed {
    logic [4:0] idx;
    logic       wr_en;
    logic       is_load;
  } slot_t;

  slot_t                  ex_q, ex_d;
  slot_t                  mem_q, mem_d;
  slot_t                  wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   rs_match;
  logic                   lu_stall;

  always_comb begin
    rs_match = (id_rs1_used && (id_rs1_idx == ex_q.idx)) ||
               (id_rs2_used && (id_rs2_idx == ex_q.idx));
    // A taken branch kills the dependent ID instruction, so no stall is needed.
    lu_stall = ex_q.is_load && ex_q.wr_en && rs_match && !ex_branch_taken;
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    cnt_d = cnt_q;
    if (!mem_stall) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (ex_branch_taken || lu_stall) begin
        ex_d = '0;
      end else begin
        ex_d.idx     = id_rd_idx;
        ex_d.wr_en   = id_rd_wr_en && (id_rd_idx != 5'd0);
        ex_d.is_load = id_is_load && id_rd_wr_en;
      end
      if (lu_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    ex_reg_wr_idx        = ex_q.idx;
    ex_reg_wr_en         = ex_q.wr_en;
    mem_reg_wr_idx       = mem_q.idx;
    mem_reg_wr_en        = mem_q.wr_en;
    wb_reg_wr_idx        = wb_q.idx;
    wb_reg_wr_en         = wb_q.wr_en;
    load_use_stall       = lu_stall;
    pc_hold              = mem_stall || lu_stall;
    ifid_hold            = mem_stall || lu_stall;
    idex_bubble          = !mem_stall && (lu_stall || ex_branch_taken);
    load_use_stall_count = cnt_q;
  end

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Randomized scoreboard bench for dest_reg_tracker with a queue-based
// reference pipeline model and a 4-bit counter to reach saturation.
module tb_dest_reg_tracker;

  localparam int unsigned CW      = 4;
  localparam int          CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rd_idx = '0;
  logic          id_rd_wr_en = 1'b0;
  logic          id_is_load = 1'b0;
  logic [4:0]    id_rs1_idx = '0;
  logic [4:0]    id_rs2_idx = '0;
  logic          id_rs1_used = 1'b0;
  logic          id_rs2_used = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_stall = 1'b0;
  logic [4:0]    ex_reg_wr_idx, mem_reg_wr_idx, wb_reg_wr_idx;
  logic          ex_reg_wr_en, mem_reg_wr_en, wb_reg_wr_en;
  logic          load_use_stall, pc_hold, ifid_hold, idex_bubble;
  logic [CW-1:0] load_use_stall_count;

  dest_reg_tracker #(.STALL_CNT_W(CW)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .id_rd_idx            (id_rd_idx),
    .id_rd_wr_en          (id_rd_wr_en),
    .id_is_load           (id_is_load),
    .id_rs1_idx           (id_rs1_idx),
    .id_rs2_idx           (id_rs2_idx),
    .id_rs1_used          (id_rs1_used),
    .id_rs2_used          (id_rs2_used),
    .ex_branch_taken      (ex_branch_taken),
    .mem_stall            (mem_stall),
    .ex_reg_wr_idx        (ex_reg_wr_idx),
    .ex_reg_wr_en         (ex_reg_wr_en),
    .mem_reg_wr_idx       (mem_reg_wr_idx),
    .mem_reg_wr_en        (mem_reg_wr_en),
    .wb_reg_wr_idx        (wb_reg_wr_idx),
    .wb_reg_wr_en         (wb_reg_wr_en),
    .load_use_stall       (load_use_stall),
    .pc_hold              (pc_hold),
    .ifid_hold            (ifid_hold),
    .idex_bubble          (idex_bubble),
    .load_use_stall_count (load_use_stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int wr;
    int ld;
  } instr_t;

  typedef struct {
    int ex_idx, ex_en, mem_idx, mem_en, wb_idx, wb_en;
    int stall, hold, bubble, cnt;
  } expect_t;

  // Model pipeline: element 0 is the instruction in EX, 1 in MEM, 2 in WB.
  instr_t  pipe[$];
  int      model_cnt;
  expect_t sb[$];
  int      n_vec = 0;
  int      n_err = 0;
  bit      done = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic instr_t nop();
    instr_t n;
    n.idx = 0; n.wr = 0; n.ld = 0;
    return n;
  endfunction

  task automatic model_reset();
    pipe.delete();
    repeat (3) pipe.push_back(nop());
    model_cnt = 0;
  endtask

  // Compute expected outputs for the current inputs, then advance the model one edge.
  task automatic model_step(input int rd, input int wr, input int ld,
                            input int r1, input int u1, input int r2, input int u2,
                            input int br, input int ms);
    expect_t e;
    instr_t  in_ex, nxt;
    int      dep, stall;
    in_ex = pipe[0];
    dep   = (u1 != 0 && r1 == in_ex.idx) || (u2 != 0 && r2 == in_ex.idx);
    stall = (in_ex.ld != 0 && in_ex.wr != 0 && dep != 0 && br == 0) ? 1 : 0;
    e.ex_idx  = pipe[0].idx; e.ex_en  = pipe[0].wr;
    e.mem_idx = pipe[1].idx; e.mem_en = pipe[1].wr;
    e.wb_idx  = pipe[2].idx; e.wb_en  = pipe[2].wr;
    e.stall   = stall;
    e.hold    = (ms != 0 || stall != 0) ? 1 : 0;
    e.bubble  = (ms == 0 && (stall != 0 || br != 0)) ? 1 : 0;
    e.cnt     = model_cnt;
    sb.push_back(e);
    if (ms == 0) begin
      if (br != 0 || stall != 0) nxt = nop();
      else begin
        nxt.idx = rd;
        nxt.wr  = (wr != 0 && rd != 0) ? 1 : 0;
        nxt.ld  = (ld != 0 && wr != 0) ? 1 : 0;
      end
      pipe.push_front(nxt);
      void'(pipe.pop_back());
      if (stall != 0 && model_cnt < CNT_MAX) model_cnt++;
    end
  endtask

  task automatic drive_random();
    int rd, wr, ld, r1, u1, r2, u2, br, ms;
    rd = $urandom_range(0, 3);
    wr = ($urandom_range(0, 3) != 0) ? 1 : 0;
    ld = ($urandom_range(0, 2) == 0) ? 1 : 0;
    r1 = $urandom_range(0, 3);
    r2 = $urandom_range(0, 3);
    u1 = $urandom_range(0, 1);
    u2 = $urandom_range(0, 1);
    br = ($urandom_range(0, 7) == 0) ? 1 : 0;
    ms = ($urandom_range(0, 5) == 0) ? 1 : 0;
    id_rd_idx       = 5'(rd);
    id_rd_wr_en     = wr[0];
    id_is_load      = ld[0];
    id_rs1_idx      = 5'(r1);
    id_rs2_idx      = 5'(r2);
    id_rs1_used     = u1[0];
    id_rs2_used     = u2[0];
    ex_branch_taken = br[0];
    mem_stall       = ms[0];
    model_step(rd, wr, ld, r1, u1, r2, u2, br, ms);
  endtask

  task automatic drive_idle();
    id_rd_idx = '0; id_rd_wr_en = 1'b0; id_is_load = 1'b0;
    id_rs1_idx = '0; id_rs2_idx = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_branch_taken = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ex_idx"},  int'(ex_reg_wr_idx), 0);
    chk({tag, "_ex_en"},   int'(ex_reg_wr_en), 0);
    chk({tag, "_mem_idx"}, int'(mem_reg_wr_idx), 0);
    chk({tag, "_mem_en"},  int'(mem_reg_wr_en), 0);
    chk({tag, "_wb_idx"},  int'(wb_reg_wr_idx), 0);
    chk({tag, "_wb_en"},   int'(wb_reg_wr_en), 0);
    chk({tag, "_stall"},   int'(load_use_stall), 0);
    chk({tag, "_pc_hold"}, int'(pc_hold), 0);
    chk({tag, "_bubble"},  int'(idex_bubble), 0);
    chk({tag, "_cnt"},     int'(load_use_stall_count), 0);
  endtask

  // Monitor: pops one expectation per cycle, away from the rising edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ex_idx",   int'(ex_reg_wr_idx),  e.ex_idx);
        chk("ex_en",    int'(ex_reg_wr_en),   e.ex_en);
        chk("mem_idx",  int'(mem_reg_wr_idx), e.mem_idx);
        chk("mem_en",   int'(mem_reg_wr_en),  e.mem_en);
        chk("wb_idx",   int'(wb_reg_wr_idx),  e.wb_idx);
        chk("wb_en",    int'(wb_reg_wr_en),   e.wb_en);
        chk("stall",    int'(load_use_stall), e.stall);
        chk("pc_hold",  int'(pc_hold),        e.hold);
        chk("ifid_hold",int'(ifid_hold),      e.hold);
        chk("bubble",   int'(idex_bubble),    e.bubble);
        chk("count",    int'(load_use_stall_count), e.cnt);
      end
    end
  end

  initial begin
    model_reset();
    drive_idle();
    #3;
    check_all_zero("reset");
    mem_stall = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    chk("reset_pc_hold_follows_mem_stall", int'(pc_hold), 1);
    chk("reset_bubble_masked_by_mem_stall", int'(idex_bubble), 0);
    mem_stall = 1'b0;
    #1;
    chk("reset_bubble_follows_branch", int'(idex_bubble), 1);
    chk("reset_stall_zero", int'(load_use_stall), 0);
    drive_idle();

    @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) begin
      @(negedge clk);
      drive_random();
    end

    // Mid-sequence asynchronous reset, asserted between clock edges.
    @(negedge clk);
    drive_idle();
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) begin
      drive_random();
      @(negedge clk);
    end
    drive_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
